// File: rtl/fifo_share_ctrl_pkg.sv
// fifo_share_ctrl_pkg
//   Shared definitions for the shared-FIFO controller: default geometry and
//   the round-robin token encoding used by rr_arb2.
package fifo_share_ctrl_pkg;

  localparam int unsigned DEF_DEPTH_BIT = 4;
  localparam int unsigned DEF_DATA_W    = 8;

  // Token names the writer that wins when both request in the same cycle.
  typedef enum logic {
    TOK_W0 = 1'b0,
    TOK_W1 = 1'b1
  } rr_tok_e;

endpackage

// File: rtl/fifo_share_ctrl_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter for the shared RAM write port.
//   Ports:
//     i_clk   - clock, rising edge
//     i_rest  - asynchronous active-low reset (token -> writer 0)
//     req     - request vector, bit n = writer n
//     enable  - grants allowed this cycle (low when FIFO full or in reset)
//     gnt     - one-hot (or zero) combinational grant
module rr_arb2
  import fifo_share_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rest,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  rr_tok_e tok;
  rr_tok_e tok_nxt;

  always_comb begin
    gnt     = '0;
    tok_nxt = tok;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (tok == TOK_W0) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
      // Whoever was just served loses priority; no grant leaves the token alone.
      if (gnt[0]) begin
        tok_nxt = TOK_W1;
      end else if (gnt[1]) begin
        tok_nxt = TOK_W0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      tok <= TOK_W0;
    end else begin
      tok <= tok_nxt;
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl
//   Sequences one shared synchronous-read FIFO RAM for two writers and one
//   reader: round-robin write arbitration, RAM strobes/addresses, pointers,
//   occupancy, full/empty and a sticky underflow flag.
//   Ports:
//     i_clk, i_rest              - clock / async active-low reset
//     i_req0/i_data0, i_req1/i_data1 - writer requests and data (hold until granted)
//     o_gnt0, o_gnt1             - combinational write grants
//     i_rd                       - consumer read request
//     o_mem_we/waddr/wdata       - RAM write port
//     o_mem_re/raddr             - RAM read port
//     o_rvalid                   - RAM read data valid (one cycle after o_mem_re)
//     o_full, o_empty, o_count   - registered occupancy status
//     o_udf, i_clr_err           - sticky underflow flag and its clear
module fifo_share_ctrl
  import fifo_share_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_BIT = DEF_DEPTH_BIT,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rest,
  input  logic                 i_req0,
  input  logic [DATA_W-1:0]    i_data0,
  input  logic                 i_req1,
  input  logic [DATA_W-1:0]    i_data1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  input  logic                 i_rd,
  output logic                 o_mem_we,
  output logic [DEPTH_BIT-1:0] o_mem_waddr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  output logic                 o_mem_re,
  output logic [DEPTH_BIT-1:0] o_mem_raddr,
  output logic                 o_rvalid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DEPTH_BIT:0]   o_count,
  output logic                 o_udf,
  input  logic                 i_clr_err
);

  localparam logic [DEPTH_BIT:0] PTR_ONE  = {{DEPTH_BIT{1'b0}}, 1'b1};
  localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

  logic [DEPTH_BIT:0] wptr;
  logic [DEPTH_BIT:0] rptr;
  logic [DEPTH_BIT:0] count;
  logic [DEPTH_BIT:0] count_nxt;
  logic               full_q;
  logic               empty_q;
  logic               rvalid_q;
  logic               udf_q;
  logic [1:0]         gnt;
  logic               arb_en;
  logic               we;
  logic               re;

  // Folding the reset level into the enable keeps grants low while reset is held.
  assign arb_en = i_rest & ~full_q;

  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rest (i_rest),
    .req    ({i_req1, i_req0}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    we = gnt[0] | gnt[1];
    re = i_rest & i_rd & ~empty_q;
    case ({we, re})
      2'b10:   count_nxt = count + PTR_ONE;
      2'b01:   count_nxt = count - PTR_ONE;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    o_gnt0      = gnt[0];
    o_gnt1      = gnt[1];
    o_mem_we    = we;
    o_mem_waddr = wptr[DEPTH_BIT-1:0];
    o_mem_wdata = gnt[1] ? i_data1 : i_data0;
    o_mem_re    = re;
    o_mem_raddr = rptr[DEPTH_BIT-1:0];
    o_rvalid    = rvalid_q;
    o_full      = full_q;
    o_empty     = empty_q;
    o_count     = count;
    o_udf       = udf_q;
  end

  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (we) begin
        wptr <= wptr + PTR_ONE;
      end
      if (re) begin
        rptr <= rptr + PTR_ONE;
      end
      count    <= count_nxt;
      full_q   <= (count_nxt == FULL_CNT);
      empty_q  <= (count_nxt == '0);
      rvalid_q <= re;
      // A fresh underflow outranks a clear in the same cycle.
      if (i_rd && empty_q) begin
        udf_q <= 1'b1;
      end else if (i_clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
module tb_fifo_share_ctrl;

  localparam int unsigned DB    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          i_clk     = 1'b0;
  logic          i_rest    = 1'b1;
  logic          i_req0    = 1'b0;
  logic [DW-1:0] i_data0   = '0;
  logic          i_req1    = 1'b0;
  logic [DW-1:0] i_data1   = '0;
  logic          i_rd      = 1'b0;
  logic          i_clr_err = 1'b0;
  logic          o_gnt0, o_gnt1, o_mem_we, o_mem_re, o_rvalid, o_full, o_empty, o_udf;
  logic [DB-1:0] o_mem_waddr, o_mem_raddr;
  logic [DW-1:0] o_mem_wdata;
  logic [DB:0]   o_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] sb_exp;

  always #5 i_clk = ~i_clk;

  fifo_share_ctrl #(.DEPTH_BIT(DB), .DATA_W(DW)) dut (
    .i_clk       (i_clk),
    .i_rest      (i_rest),
    .i_req0      (i_req0),
    .i_data0     (i_data0),
    .i_req1      (i_req1),
    .i_data1     (i_data1),
    .o_gnt0      (o_gnt0),
    .o_gnt1      (o_gnt1),
    .i_rd        (i_rd),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_re    (o_mem_re),
    .o_mem_raddr (o_mem_raddr),
    .o_rvalid    (o_rvalid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_udf       (o_udf),
    .i_clr_err   (i_clr_err)
  );

  // Synchronous-read RAM driven by the controller strobes.
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_waddr] <= o_mem_wdata;
    if (o_mem_re) ram_q <= mem[o_mem_raddr];
  end

  // Scoreboard: every valid read must return the next accepted write, in order.
  always @(negedge i_clk) begin
    if (i_rest && o_rvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underrun: rvalid with no expected data, got %h", ram_q);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ram_q !== sb_exp) begin
          bad++;
          $display("FAIL sb_data: got %h expected %h", ram_q, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    i_rest = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    i_rest = 1'b1;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      i_req0 = 1'b1; i_data0 = base + DW'(i);
      exp_q.push_back(base + DW'(i));
      @(negedge i_clk);
    end
    i_req0 = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      i_rd = 1'b1;
      @(negedge i_clk);
    end
    i_rd = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    #2 i_rest = 1'b0; i_req0 = 1'b1; i_req1 = 1'b1; i_rd = 1'b1;
    #1;
    total++;
    if ({o_gnt0, o_gnt1, o_mem_we, o_mem_re, o_full, o_empty, o_rvalid, o_udf} !== 8'b0000_0100) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 00000100",
               {o_gnt0, o_gnt1, o_mem_we, o_mem_re, o_full, o_empty, o_rvalid, o_udf});
    end
    total++;
    if (o_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    i_req0 = 1'b0; i_req1 = 1'b0; i_rd = 1'b0;
    @(negedge i_clk);
    i_rest = 1'b1;
  endtask

  task automatic test_single_writer();
    for (int i = 0; i < 16; i++) begin
      i_req0 = 1'b1; i_data0 = 8'hA0 + DW'(i);
      #1;
      total++;
      if ({o_gnt0, o_gnt1, o_mem_we} !== 3'b101) begin
        bad++; $display("FAIL sw_gnt[%0d]: got %b expected 101", i, {o_gnt0, o_gnt1, o_mem_we});
      end
      total++;
      if (o_mem_waddr !== DB'(i)) begin
        bad++; $display("FAIL sw_waddr[%0d]: got %0d expected %0d", i, o_mem_waddr, i);
      end
      total++;
      if (o_mem_wdata !== 8'hA0 + DW'(i)) begin
        bad++; $display("FAIL sw_wdata[%0d]: got %h expected %h", i, o_mem_wdata, 8'hA0 + DW'(i));
      end
      exp_q.push_back(8'hA0 + DW'(i));
      @(negedge i_clk);
      total++;
      if (o_count !== 5'(i + 1)) begin
        bad++; $display("FAIL sw_count[%0d]: got %0d expected %0d", i, o_count, i + 1);
      end
      total++;
      if ({o_full, o_empty} !== {(i == 15), 1'b0}) begin
        bad++; $display("FAIL sw_flags[%0d]: got %b expected %b", i, {o_full, o_empty}, {(i == 15), 1'b0});
      end
    end
    i_data0 = 8'hEE;
    #1;
    total++;
    if ({o_gnt0, o_mem_we} !== 2'b00) begin
      bad++; $display("FAIL sw_full_block: got %b expected 00", {o_gnt0, o_mem_we});
    end
    @(negedge i_clk);
    total++;
    if (o_count !== 5'd16) begin bad++; $display("FAIL sw_count_hold: got %0d expected 16", o_count); end
    i_req0 = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      i_rd = 1'b1;
      #1;
      total++;
      if ({o_mem_re, o_mem_raddr} !== {1'b1, DB'(i)}) begin
        bad++; $display("FAIL dr_raddr[%0d]: got re=%b addr=%0d expected re=1 addr=%0d", i, o_mem_re, o_mem_raddr, i);
      end
      @(negedge i_clk);
      total++;
      if (o_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid[%0d]: got %b expected 1", i, o_rvalid); end
      total++;
      if ({o_count, o_full, o_empty, o_udf} !== {5'(15 - i), 1'b0, (i == 15), 1'b0}) begin
        bad++; $display("FAIL dr_status[%0d]: got cnt=%0d f=%b e=%b u=%b expected cnt=%0d", i,
                        o_count, o_full, o_empty, o_udf, 15 - i);
      end
    end
    #1;
    total++;
    if (o_mem_re !== 1'b0) begin bad++; $display("FAIL dr_empty_block: got re=%b expected 0", o_mem_re); end
    @(negedge i_clk);
    total++;
    if ({o_udf, o_rvalid, o_count} !== {1'b1, 1'b0, 5'd0}) begin
      bad++; $display("FAIL dr_udf: got udf=%b rvalid=%b cnt=%0d expected udf=1 rvalid=0 cnt=0", o_udf, o_rvalid, o_count);
    end
    i_clr_err = 1'b1;
    @(negedge i_clk);
    total++;
    if (o_udf !== 1'b1) begin bad++; $display("FAIL udf_set_wins: got %b expected 1", o_udf); end
    i_rd = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_udf !== 1'b0) begin bad++; $display("FAIL udf_clear: got %b expected 0", o_udf); end
    i_clr_err = 1'b0;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL dr_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    logic g0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      // 0..5 both request; 6 writer 0 alone; 7 both again (token moved to writer 1)
      g0 = (i < 6) ? (i % 2 == 0) : (i == 6);
      i_req0 = 1'b1; i_req1 = (i != 6);
      i_data0 = 8'h10 + DW'(i); i_data1 = 8'h20 + DW'(i);
      #1;
      total++;
      if ({o_gnt0, o_gnt1} !== {g0, ~g0}) begin
        bad++; $display("FAIL ct_gnt[%0d]: got %b expected %b", i, {o_gnt0, o_gnt1}, {g0, ~g0});
      end
      total++;
      if (o_mem_wdata !== (g0 ? i_data0 : i_data1)) begin
        bad++; $display("FAIL ct_wdata[%0d]: got %h expected %h", i, o_mem_wdata, g0 ? i_data0 : i_data1);
      end
      exp_q.push_back(g0 ? 8'h10 + DW'(i) : 8'h20 + DW'(i));
      @(negedge i_clk);
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    #1;
    total++;
    if ({o_gnt0, o_gnt1, o_mem_we} !== 3'b000) begin
      bad++; $display("FAIL ct_idle: got %b expected 000", {o_gnt0, o_gnt1, o_mem_we});
    end
    total++;
    if (o_count !== 5'd8) begin bad++; $display("FAIL ct_count: got %0d expected 8", o_count); end
    @(negedge i_clk);
    drain(8);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL ct_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fill(8, 8'h40);
    for (int i = 0; i < 20; i++) begin
      i_req0 = 1'b1; i_data0 = 8'h50 + DW'(i); i_rd = 1'b1;
      #1;
      total++;
      if ({o_gnt0, o_mem_we, o_mem_re, o_mem_waddr, o_mem_raddr} !== {3'b111, DB'(8 + i), DB'(i)}) begin
        bad++; $display("FAIL sim_ports[%0d]: got we=%b re=%b wa=%0d ra=%0d expected wa=%0d ra=%0d", i,
                        o_mem_we, o_mem_re, o_mem_waddr, o_mem_raddr, (8 + i) % 16, i % 16);
      end
      exp_q.push_back(8'h50 + DW'(i));
      @(negedge i_clk);
      total++;
      if ({o_count, o_full, o_empty} !== {5'd8, 2'b00}) begin
        bad++; $display("FAIL sim_count[%0d]: got cnt=%0d f=%b e=%b expected cnt=8", i, o_count, o_full, o_empty);
      end
    end
    i_req0 = 1'b0; i_rd = 1'b0;
    drain(8);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sim_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_full_read();
    do_reset();
    fill(16, 8'h60);
    total++;
    if ({o_full, o_count} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL fr_fill: got f=%b cnt=%0d expected f=1 cnt=16", o_full, o_count);
    end
    i_req0 = 1'b1; i_data0 = 8'h77; i_rd = 1'b1;
    #1;
    total++;
    if ({o_gnt0, o_mem_re} !== 2'b01) begin
      bad++; $display("FAIL fr_block: got gnt0=%b re=%b expected gnt0=0 re=1", o_gnt0, o_mem_re);
    end
    @(negedge i_clk);
    total++;
    if ({o_full, o_count} !== {1'b0, 5'd15}) begin
      bad++; $display("FAIL fr_after_read: got f=%b cnt=%0d expected f=0 cnt=15", o_full, o_count);
    end
    i_rd = 1'b0;
    #1;
    total++;
    if ({o_gnt0, o_mem_waddr} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL fr_regrant: got gnt0=%b wa=%0d expected gnt0=1 wa=0", o_gnt0, o_mem_waddr);
    end
    exp_q.push_back(8'h77);
    @(negedge i_clk);
    i_req0 = 1'b0;
    total++;
    if ({o_full, o_count} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL fr_refull: got f=%b cnt=%0d expected f=1 cnt=16", o_full, o_count);
    end
    drain(16);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL fr_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(4, 8'h80);
    i_rd = 1'b1;
    @(posedge i_clk);
    #2;
    i_rest = 1'b0; i_req0 = 1'b1;
    #1;
    total++;
    if ({o_gnt0, o_gnt1, o_mem_we, o_mem_re, o_full, o_empty, o_rvalid, o_udf} !== 8'b0000_0100) begin
      bad++;
      $display("FAIL rm_flags: got %b expected 00000100",
               {o_gnt0, o_gnt1, o_mem_we, o_mem_re, o_full, o_empty, o_rvalid, o_udf});
    end
    total++;
    if (o_count !== 5'd0) begin bad++; $display("FAIL rm_count: got %0d expected 0", o_count); end
    exp_q.delete();
    @(negedge i_clk);
    i_rest = 1'b1; i_req0 = 1'b1; i_data0 = 8'h99; i_rd = 1'b0;
    #1;
    total++;
    if ({o_gnt0, o_mem_waddr} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL rm_waddr: got gnt0=%b wa=%0d expected gnt0=1 wa=0", o_gnt0, o_mem_waddr);
    end
    exp_q.push_back(8'h99);
    @(negedge i_clk);
    i_req0 = 1'b0; i_rd = 1'b1;
    #1;
    total++;
    if ({o_mem_re, o_mem_raddr} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL rm_raddr: got re=%b ra=%0d expected re=1 ra=0", o_mem_re, o_mem_raddr);
    end
    @(negedge i_clk);
    i_rd = 1'b0;
    @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rm_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_drain();
    test_contention();
    test_simultaneous();
    test_full_read();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
